sim_verdict: RTL

SIM_VERDICT -- requirements
Module: sim_verdict

---
 rtl/sim_verdict.sv | 119 +++++++++++
 1 files changed

// File: rtl/sim_verdict.sv
// sim_verdict: harness pass/fail verdict FSM with check counters.
// Ports: clk, reset (async, high), cyc_cnt[31:0], start, check_valid,
//   check_ok, done in; passed, failed, chk_cnt[15:0], err_cnt[15:0],
//   state[2:0] (IDLE=0 RUN=1 DRAIN=2 PASS=3 FAIL=4) out.
// Optional macro SIM_VERDICT_TIMEOUT_EN adds the MAX_CYC watchdog.
module sim_verdict #(
  parameter int MIN_CHECKS = 1,
  parameter int DRAIN_CYC  = 4,
  parameter int MAX_CYC    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cyc_cnt,
  input  logic        start,
  input  logic        check_valid,
  input  logic        check_ok,
  input  logic        done,
  output logic        passed,
  output logic        failed,
  output logic [15:0] chk_cnt,
  output logic [15:0] err_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } st_t;

  localparam logic [7:0]  DRN   = 8'(DRAIN_CYC);
  localparam logic [16:0] MIN_C = 17'(MIN_CHECKS);

  st_t         st_q, st_d;
  logic [7:0]  drn_q, drn_d;
  logic [15:0] chk_q, chk_d;
  logic [15:0] err_q, err_d;
  logic        pass_q, fail_q;
  logic        active, ok_chk, bad_chk, timeout;

  assign active  = (st_q == S_RUN) || (st_q == S_DRAIN);
  assign ok_chk  = active && check_valid && check_ok;
  assign bad_chk = active && check_valid && !check_ok;

`ifdef SIM_VERDICT_TIMEOUT_EN
  assign timeout = active && (cyc_cnt >= 32'(MAX_CYC));
`else
  logic unused_cyc;
  assign unused_cyc = ^{cyc_cnt, 32'(MAX_CYC)};
  assign timeout    = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    drn_d = drn_q;
    chk_d = chk_q;
    err_d = err_q;
    if (ok_chk && (chk_q != 16'hFFFF))
      chk_d = chk_q + 16'd1;
    if (bad_chk && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
    unique case (st_q)
      S_IDLE: begin
        if (start)
          st_d = S_RUN;
      end
      S_RUN: begin
        if (bad_chk) begin
          st_d = S_FAIL;
        end else if (done) begin
          st_d  = S_DRAIN;
          drn_d = DRN;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q - 8'd1;
        if (bad_chk) begin
          st_d = S_FAIL;
        end else if (drn_q == 8'd1) begin
          // verdict uses counts that include this last cycle's check
          if ((err_d == 16'd0) && ({1'b0, chk_d} >= MIN_C))
            st_d = S_PASS;
          else
            st_d = S_FAIL;
        end
      end
      default: ;
    endcase
    if (timeout)
      st_d = S_FAIL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_IDLE;
      drn_q  <= 8'd0;
      chk_q  <= 16'd0;
      err_q  <= 16'd0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      drn_q  <= drn_d;
      chk_q  <= chk_d;
      err_q  <= err_d;
      pass_q <= (st_d == S_PASS);
      fail_q <= (st_d == S_FAIL);
    end
  end

  assign passed  = pass_q;
  assign failed  = fail_q;
  assign chk_cnt = chk_q;
  assign err_cnt = err_q;
  assign state   = st_q;

endmodule
